// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch front-end sequencer.
package watch_pkg;

  localparam int unsigned NUM_MODES = 4;

  typedef enum logic [1:0] {
    CLOCK12   = 2'd0,
    CLOCK24   = 2'd1,
    ALARM     = 2'd2,
    STOPWATCH = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    DISPLAY = 2'd0,
    SETTING = 2'd1,
    COMMIT  = 2'd2
  } ctrl_state_t;

  function automatic logic [NUM_MODES-1:0] onehot4(input mode_t m);
    return NUM_MODES'(1) << m;
  endfunction

endpackage

// File: rtl/watch_mode_controller_if.sv
// Button, setter-handshake and routed-output bundle of the mode controller.
interface watch_mode_controller_if;
  import watch_pkg::*;

  logic                 pulsed_mode;
  logic                 pulsed_set;
  logic                 pulsed_up;
  logic                 pulsed_down;
  logic                 real_quarter;
  logic [NUM_MODES-1:0] set_busy;
  logic [NUM_MODES-1:0] set_propagate;

  mode_t                mode;
  logic [NUM_MODES-1:0] set_enable;
  logic [NUM_MODES-1:0] fwd_set;
  logic [NUM_MODES-1:0] fwd_up;
  logic [NUM_MODES-1:0] fwd_down;
  logic [NUM_MODES-1:0] abort;
  logic                 time_propagate;
  mode_t                prop_src;
  logic                 blink;

  modport master (
    output pulsed_mode, pulsed_set, pulsed_up, pulsed_down, real_quarter,
           set_busy, set_propagate,
    input  mode, set_enable, fwd_set, fwd_up, fwd_down, abort,
           time_propagate, prop_src, blink
  );

  modport slave (
    input  pulsed_mode, pulsed_set, pulsed_up, pulsed_down, real_quarter,
           set_busy, set_propagate,
    output mode, set_enable, fwd_set, fwd_up, fwd_down, abort,
           time_propagate, prop_src, blink
  );

endinterface

// File: rtl/watch_mode_controller_quarter_timeout.sv
// Saturating idle counter of real_quarter ticks; expired is high once the limit is held.
module quarter_timeout #(
  parameter int unsigned TIMEOUT_QUARTERS = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_QUARTERS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_QUARTERS);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Clear beats tick; the counter parks at LIMIT instead of wrapping.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (tick && (count != LIMIT)) begin
      count_next = count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == LIMIT);
    end
  end

endmodule

// File: rtl/watch_mode_controller.sv
// Watch mode sequencer: mode cycling, button routing, set-session timeout and commit arbitration.
module watch_mode_controller
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_QUARTERS = 120
) (
  input logic                    clk,
  input logic                    reset,
  watch_mode_controller_if.slave bus
);

  ctrl_state_t          state, state_next;
  mode_t                mode_q, mode_next;
  mode_t                prop_src_q, prop_src_next;
  logic [NUM_MODES-1:0] set_enable_q, set_enable_next;
  logic [NUM_MODES-1:0] fwd_set_q, fwd_set_next;
  logic [NUM_MODES-1:0] fwd_up_q, fwd_up_next;
  logic [NUM_MODES-1:0] fwd_down_q, fwd_down_next;
  logic [NUM_MODES-1:0] abort_q, abort_next;
  logic [NUM_MODES-1:0] busy_d;
  logic                 time_propagate_q, time_propagate_next;
  logic                 blink_q, blink_next;
  logic                 phase_q, phase_next;

  logic busy_cur, busy_rise, prop_cur, btn_any, expired;
  logic may_commit, to_clear, to_tick;

  assign busy_cur   = bus.set_busy[mode_q];
  assign busy_rise  = busy_cur && !busy_d[mode_q];
  assign prop_cur   = bus.set_propagate[mode_q];
  assign btn_any    = bus.pulsed_mode || bus.pulsed_set || bus.pulsed_up || bus.pulsed_down;
  assign may_commit = (mode_q == CLOCK12) || (mode_q == CLOCK24);
  assign to_clear   = ((state == DISPLAY) && busy_rise) || ((state == SETTING) && btn_any);
  assign to_tick    = (state == SETTING) && bus.real_quarter;

  quarter_timeout #(
    .TIMEOUT_QUARTERS(TIMEOUT_QUARTERS)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (to_clear),
    .tick   (to_tick),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= DISPLAY;
    else       state <= state_next;
  end

  // Propagate outranks timeout, timeout outranks a plain busy drop.
  always_comb begin
    state_next = state;
    unique case (state)
      DISPLAY: if (busy_rise) state_next = SETTING;
      SETTING: begin
        if (prop_cur)       state_next = may_commit ? COMMIT : DISPLAY;
        else if (expired)   state_next = DISPLAY;
        else if (!busy_cur) state_next = DISPLAY;
      end
      COMMIT:  state_next = DISPLAY;
      default: state_next = DISPLAY;
    endcase
  end

  always_comb begin
    mode_next           = mode_q;
    prop_src_next       = prop_src_q;
    fwd_set_next        = '0;
    fwd_up_next         = '0;
    fwd_down_next       = '0;
    abort_next          = '0;
    time_propagate_next = 1'b0;
    blink_next          = 1'b0;
    phase_next          = 1'b0;

    if (bus.pulsed_set && !((state == DISPLAY) && bus.pulsed_mode)) fwd_set_next = onehot4(mode_q);
    if (bus.pulsed_up && !bus.pulsed_down) fwd_up_next = onehot4(mode_q);
    if (bus.pulsed_down && !bus.pulsed_up) fwd_down_next = onehot4(mode_q);

    unique case (state)
      DISPLAY: if (!busy_rise && bus.pulsed_mode) mode_next = mode_t'(2'(mode_q + 2'd1));
      SETTING: if (!prop_cur && expired) abort_next = onehot4(mode_q);
      COMMIT: begin
        time_propagate_next = 1'b1;
        prop_src_next       = mode_q;
      end
      default: ;
    endcase

    // Blink flips on every second quarter while the session stays open.
    if ((state == SETTING) && (state_next == SETTING)) begin
      phase_next = phase_q ^ bus.real_quarter;
      blink_next = blink_q ^ (bus.real_quarter & phase_q);
    end

    set_enable_next = onehot4(mode_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q           <= CLOCK12;
      prop_src_q       <= CLOCK12;
      set_enable_q     <= NUM_MODES'(1);
      fwd_set_q        <= '0;
      fwd_up_q         <= '0;
      fwd_down_q       <= '0;
      abort_q          <= '0;
      time_propagate_q <= 1'b0;
      blink_q          <= 1'b0;
      phase_q          <= 1'b0;
      busy_d           <= '0;
    end else begin
      mode_q           <= mode_next;
      prop_src_q       <= prop_src_next;
      set_enable_q     <= set_enable_next;
      fwd_set_q        <= fwd_set_next;
      fwd_up_q         <= fwd_up_next;
      fwd_down_q       <= fwd_down_next;
      abort_q          <= abort_next;
      time_propagate_q <= time_propagate_next;
      blink_q          <= blink_next;
      phase_q          <= phase_next;
      busy_d           <= bus.set_busy;
    end
  end

  assign bus.mode           = mode_q;
  assign bus.prop_src       = prop_src_q;
  assign bus.set_enable     = set_enable_q;
  assign bus.fwd_set        = fwd_set_q;
  assign bus.fwd_up         = fwd_up_q;
  assign bus.fwd_down       = fwd_down_q;
  assign bus.abort          = abort_q;
  assign bus.time_propagate = time_propagate_q;
  assign bus.blink          = blink_q;

endmodule
